// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths and datapath types
package aes_pkg;

    localparam int AES_BLOCK_W    = 128;
    localparam int AES_NR         = 10;
    localparam int AES_KEYSCHED_W = (AES_NR + 1) * AES_BLOCK_W;
    localparam int AES_ROUND_W    = 4;

    typedef logic [AES_BLOCK_W-1:0]    block_t;
    typedef logic [AES_KEYSCHED_W-1:0] keysched_t;
    typedef logic [AES_ROUND_W-1:0]    round_t;

endpackage : aes_pkg

// File: rtl/round_key_select.sv
// rtl/round_key_select.sv - picks one round key out of the expanded schedule
module round_key_select
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int NR      = AES_NR
) (
    input  logic [(NR+1)*BLOCK_W-1:0] key,
    input  logic [AES_ROUND_W-1:0]    roundnumber,
    output logic [BLOCK_W-1:0]        rk
);

    localparam int KEY_W = (NR + 1) * BLOCK_W;

    // Round 0 sits in the top slice; any index beyond NR yields an all-zero key
    always_comb begin
        rk = '0;
        for (int k = 0; k <= NR; k++) begin
            if (roundnumber == AES_ROUND_W'(k)) begin
                rk = key[KEY_W-1-BLOCK_W*k -: BLOCK_W];
            end
        end
    end

endmodule : round_key_select

// File: rtl/add_round_key.sv
// rtl/add_round_key.sv - registered AES AddRoundKey stage
module add_round_key
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int NR      = AES_NR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BLOCK_W-1:0]         state,
    input  logic [(NR+1)*BLOCK_W-1:0]  key,
    input  logic [AES_ROUND_W-1:0]     roundnumber,
    input  logic                       start,
    output logic [BLOCK_W-1:0]         result,
    output logic                       finish
);

    logic [BLOCK_W-1:0] rk;
    logic [BLOCK_W-1:0] mixed;

    round_key_select #(
        .BLOCK_W (BLOCK_W),
        .NR      (NR)
    ) u_round_key_select (
        .key         (key),
        .roundnumber (roundnumber),
        .rk          (rk)
    );

    // Key addition is a plain bytewise XOR with no reordering
    always_comb begin
        mixed = state ^ rk;
    end

    // Output stage: capture on start, hold otherwise; finish is a one-cycle echo of start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            finish <= 1'b0;
        end else begin
            finish <= start;
            if (start) begin
                result <= mixed;
            end
        end
    end

endmodule : add_round_key

// File: tb/tb_add_round_key.sv
// tb/tb_add_round_key.sv - directed self-checking bench for add_round_key
module tb_add_round_key;

    logic            clk;
    logic            rst;
    logic [127:0]    state_in;
    logic [1407:0]   key;
    logic [3:0]      roundnumber;
    logic            start;
    logic [127:0]    result;
    logic            finish;

    logic [127:0]    rk_tab [0:10];
    logic [127:0]    sweep_state;
    logic [127:0]    held;
    int              n_cmp;
    int              n_fail;

    add_round_key dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state_in),
        .key         (key),
        .roundnumber (roundnumber),
        .start       (start),
        .result      (result),
        .finish      (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        rk_tab[0]  = 128'h657870616E642033322D62797465206B;
        rk_tab[1]  = 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90;
        rk_tab[2]  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        rk_tab[3]  = 128'hDEADBEEF0123456789ABCDEFFEEDFACE;
        rk_tab[4]  = 128'h13579BDF2468ACE0F0E1D2C3B4A59687;
        rk_tab[5]  = 128'h37F806501C32EE525B58C76779AF9A41;
        rk_tab[6]  = 128'hC0FFEE00BADC0DE0123400FF5A5AA5A5;
        rk_tab[7]  = 128'h8899AABBCCDDEEFF0011223344556677;
        rk_tab[8]  = 128'h7F6E5D4C3B2A19080706050403020100;
        rk_tab[9]  = 128'hF0F0F0F00F0F0F0FAAAA5555CCCC3333;
        rk_tab[10] = 128'h55AA55AA00FF00FF1234ABCD9876FEDC;
        key = {rk_tab[0], rk_tab[1], rk_tab[2], rk_tab[3], rk_tab[4], rk_tab[5],
               rk_tab[6], rk_tab[7], rk_tab[8], rk_tab[9], rk_tab[10]};

        // Reset held for 3 cycles with start high
        rst         = 1'b0;
        start       = 1'b1;
        state_in    = 128'h000102030405060708090A0B0C0D0E0F;
        roundnumber = 4'd5;
        tick();
        tick();
        tick();
        check("reset_result", result, 128'h0);
        check("reset_finish", {127'h0, finish}, 128'h1 & 128'h0);

        // Release: first sample is the round-5 vector
        rst = 1'b1;
        tick();
        check("rel_finish", {127'h0, finish}, 128'h1);
        check("round5_result", result, 128'h37F904531837E8555351CD6C75A2944E);

        // Round 0 with zero state returns the whitening key itself
        state_in    = 128'h0;
        roundnumber = 4'd0;
        tick();
        check("round0_result", result, 128'h657870616E642033322D62797465206B);
        check("round0_finish", {127'h0, finish}, 128'h1);

        // Back-to-back sweep over all rounds, start held high
        sweep_state = 128'h3243F6A8885A308D313198A2E0370734;
        state_in    = sweep_state;
        for (int k = 0; k <= 10; k++) begin
            roundnumber = 4'(k);
            tick();
            check($sformatf("sweep%0d_result", k), result, sweep_state ^ rk_tab[k]);
            check($sformatf("sweep%0d_finish", k), {127'h0, finish}, 128'h1);
        end

        // Out-of-range indices pass state through unchanged
        state_in    = 128'hCAFEBABE112233445566778899AABBCC;
        roundnumber = 4'd11;
        tick();
        check("rn11_result", result, 128'hCAFEBABE112233445566778899AABBCC);
        state_in    = 128'h0123456789ABCDEF0011223344556677;
        roundnumber = 4'd12;
        tick();
        check("rn12_result", result, 128'h0123456789ABCDEF0011223344556677);
        check("rn12_finish", {127'h0, finish}, 128'h1);
        held = 128'h0123456789ABCDEF0011223344556677;

        // start low: inputs ignored, result held, finish drops
        start       = 1'b0;
        state_in    = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
        roundnumber = 4'd3;
        tick();
        check("idle1_result", result, held);
        check("idle1_finish", {127'h0, finish}, 128'h0);
        state_in = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
        tick();
        check("idle2_result", result, held);

        // Mid-stream asynchronous reset clears outputs before the next edge
        start       = 1'b1;
        state_in    = 128'h00112233445566778899AABBCCDDEEFF;
        roundnumber = 4'd10;
        tick();
        check("pre_rst_result", result, 128'h00112233445566778899AABBCCDDEEFF ^ 128'h55AA55AA00FF00FF1234ABCD9876FEDC);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_result", result, 128'h0);
        check("async_rst_finish", {127'h0, finish}, 128'h0);
        tick();
        check("held_rst_result", result, 128'h0);
        check("held_rst_finish", {127'h0, finish}, 128'h0);
        rst = 1'b1;
        tick();
        check("rerel_finish", {127'h0, finish}, 128'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_add_round_key
